// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: N add/shift steps per request,
// result held in product until the next multiply completes.
module seq_shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic [2*N-1:0]   product,
  output logic             busy,
  output logic             done,
  output logic             bin2BCD_start_en
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic               start_d;
  logic [N-1:0]       mcand_reg;
  logic [N-1:0]       mplier_reg;
  logic [2*N:0]       acc_reg;
  logic [2*N:0]       acc_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [N-1:0]       addend;
  logic [N:0]         sum;
  logic               request;

  // Partial product for this step: multiplicand gated by the current multiplier LSB.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  // Carry of the add lands in the top accumulator bit and is shifted down with the rest.
  always_comb begin
    sum      = {acc_reg[2*N], acc_reg[2*N-1:N]} + {1'b0, addend};
    acc_next = {sum, acc_reg[N-1:0]} >> 1;
  end

  assign request = start & ~start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      start_d          <= 1'b0;
      mcand_reg        <= '0;
      mplier_reg       <= '0;
      acc_reg          <= '0;
      cnt_reg          <= '0;
      product          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      bin2BCD_start_en <= 1'b0;
    end else begin
      start_d <= start;
      done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (request) begin
            mcand_reg        <= a_in;
            mplier_reg       <= b_in;
            acc_reg          <= '0;
            cnt_reg          <= '0;
            bin2BCD_start_en <= 1'b0;
            busy             <= 1'b1;
            state_reg        <= CALC;
          end
        end
        CALC: begin
          acc_reg    <= acc_next;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          // Fixed-length loop: no early exit, so latency is independent of operands.
          if (cnt_reg == LAST_STEP) begin
            product          <= acc_next[2*N-1:0];
            done             <= 1'b1;
            bin2BCD_start_en <= 1'b1;
            state_reg        <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

Interface
REQ-001 The block SHALL have one parameter: N, default 4, operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request level; a 0->1 transition requests a multiply.
REQ-005 The block SHALL have port a_in, input, N, multiplicand (unsigned).
REQ-006 The block SHALL have port b_in, input, N, multiplier (unsigned).
REQ-007 The block SHALL have port product, output, 2N, registered result of the last completed multiply.
REQ-008 The block SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking a new valid product.
REQ-010 The block SHALL have port bin2BCD_start_en, output, 1, qualifier for the downstream BCD converter; high while product holds a valid completed result.

Function
REQ-011 The block SHALL implement states IDLE, CALC and DONE, held in a registered state variable.
REQ-012 The block SHALL register start each cycle (start_d) and detect a request as start=1 and start_d=0.
REQ-013 In IDLE, on a detected request (cycle c0), the block SHALL latch a_in and b_in, clear the accumulator, clear the step counter, drop bin2BCD_start_en to 0 and enter CALC at c1.
REQ-014 In CALC, each cycle the block SHALL add the latched multiplicand to the upper N bits of the accumulator if the current multiplier LSB is 1, then shift the (2N+1)-bit {carry, acc_hi, acc_lo} right by one.
REQ-015 The accumulator SHALL be 2N+1 bits wide so the carry of every add is retained; no overflow is possible in the 2N-bit result.
REQ-016 CALC SHALL last exactly N cycles (c1..cN) regardless of operand values; there is no early termination on zero operands.
REQ-017 At cycle c(N+1) the block SHALL be in DONE with product = a_in*b_in (as latched at c0), done=1 and bin2BCD_start_en=1.
REQ-018 DONE SHALL last one cycle and return unconditionally to IDLE; done SHALL be 0 in all other cycles.
REQ-019 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-020 product SHALL change only on entry to DONE; it holds the previous result throughout IDLE and CALC.
REQ-021 bin2BCD_start_en SHALL remain 1 from DONE until the next accepted request, then be 0 from c1 until the following DONE.
REQ-022 Requests detected while busy=1 SHALL be ignored and not queued.
REQ-023 start held high continuously SHALL produce exactly one multiply; a new request needs start to return to 0 first.
REQ-024 A request detected in the first IDLE cycle after DONE SHALL be accepted (back-to-back operation, c0 immediately after DONE).
REQ-025 Changes to a_in or b_in after c0 SHALL not affect the result in progress.

Reset
REQ-026 On rst_n=0 the block SHALL immediately, without a clock, force state=IDLE, product=0, done=0, busy=0, bin2BCD_start_en=0, start_d=0, accumulator and counter to 0.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse and no product update.
REQ-028 After rst_n release, if start is already 1, the first clock SHALL detect a request (start_d=0).

Verification
REQ-029 a_in=15, b_in=15, start 0->1 at c0 -> busy 1 at c1..c5, done=1 and product=8'hE1 (225) at c5, bin2BCD_start_en=1 from c5.
REQ-030 a_in=0, b_in=9 -> product=0, done pulse still exactly at c5; then a_in=7, b_in=3 back-to-back -> product=21 at next DONE.
REQ-031 start held high 20 cycles with a_in=5, b_in=6 -> exactly one done pulse, product=30.
REQ-032 Second start pulse at c2 during a 12*11 multiply -> ignored, single done at c5, product=132, no second done.
REQ-033 rst_n pulled low at c3 of a 9*9 multiply -> all outputs 0 immediately, no done; after release a fresh 9*9 request gives product=81.
REQ-034 a_in/b_in changed at c1 after 10*4 request -> product=40.
